// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Oversampling is fixed at 16 ticks per bit; the frame FSM states are encoded in 2 bits.
package fifo_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned OVS      = 16;
  localparam logic [4:0]  OVS_LAST = 5'(OVS - 1);

  // Last tick index of a phase lasting n oversample ticks (n <= 32).
  function automatic logic [4:0] last_tick(input int unsigned n);
    return 5'(n - 1);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side port group of a first-word-fall-through FIFO.
// master = the consumer issuing pops, slave = the FIFO itself.
interface fifo_uart_tx_if #(
  parameter int DBIT = 8
);
  logic            empty;
  logic [DBIT-1:0] r_data;
  logic            rd;

  modport master (output rd, input empty, input r_data);
  modport slave  (input rd, output empty, output r_data);
endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Mod-M oversample tick generator with a synchronous clear.
// Shared between the UART transmitter and receiver.
module baud_gen #(
  parameter int M = 163,
  parameter int N = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam logic [N-1:0] CNT_LAST = N'(M - 1);

  logic [N-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {N{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = {N{1'b0}};
    end else begin
      cnt_d = cnt_q + N'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {N{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a FWFT word FIFO: pops in idle, then sends
// start bit, DBIT data bits LSB-first and an SB_TICK-tick stop bit.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  localparam int         IDX_W     = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DBIT - 1);
  localparam logic [4:0] STOP_LAST = last_tick(SB_TICK);

  tx_state_e        state_q, state_d;
  logic [4:0]       tick_q, tick_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DBIT-1:0]  sreg_q, sreg_d;
  logic             tx_q, tx_d;
  logic             s_tick;
  logic             rd_s;

  // Restart the divisor on the pop cycle so the start bit is a full bit long.
  baud_gen #(
    .M (DVSR),
    .N (DVSR_W)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (rd_s),
    .tick  (s_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tick_q  <= 5'd0;
      idx_q   <= {IDX_W{1'b0}};
      sreg_q  <= {DBIT{1'b0}};
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      sreg_q  <= sreg_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    sreg_d  = sreg_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_s) begin
          sreg_d  = fifo.r_data;
          tick_d  = 5'd0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (tick_q == OVS_LAST) begin
            tick_d  = 5'd0;
            idx_d   = {IDX_W{1'b0}};
            state_d = ST_DATA;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end else begin
          tick_d = tick_q;
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (tick_q == OVS_LAST) begin
            tick_d = 5'd0;
            sreg_d = sreg_q >> 1;
            if (idx_q == IDX_LAST) begin
              state_d = ST_STOP;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end else begin
          tick_d = tick_q;
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (tick_q == STOP_LAST) begin
            tick_d  = 5'd0;
            state_d = ST_IDLE;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end else begin
          tick_d = tick_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Line level follows the next state so tx changes in step with state_q.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = sreg_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    rd_s         = reset & (state_q == ST_IDLE) & ~fifo.empty;
    tx_busy      = (state_q != ST_IDLE);
    tx_done_tick = (state_q == ST_STOP) & s_tick & (tick_q == STOP_LAST);
  end

  assign fifo.rd = rd_s;
  assign tx      = tx_q;

endmodule
